// File: rtl/adaptive_threshold_pkg.sv
// Shared FSM encoding, binary output levels and the foreground test
// used by the adaptive threshold controller and its scanner.
package adaptive_threshold_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BLUR   = 3'd1,
    THRESH = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [7:0] FG_VALUE = 8'd255;
  localparam logic [7:0] BG_VALUE = 8'd0;

  // pixel > mean - C, evaluated as pixel + C > mean in 9 bits so neither side wraps
  function automatic logic is_foreground(input logic [7:0] pixel,
                                         input logic [7:0] offset,
                                         input logic [7:0] mean);
    return ({1'b0, pixel} + {1'b0, offset}) > {1'b0, mean};
  endfunction

endpackage

// File: rtl/adaptive_threshold_ctrl_if.sv
// Control, box-filter and memory-port bundle for adaptive_threshold_ctrl.
// master = controller side, slave = filter/memories/host side.
interface adaptive_threshold_ctrl_if #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8
);
  logic                   iStart;
  logic [7:0]             iOffset;
  logic                   oBusy;
  logic                   oDone;
  logic                   oFilterReset;
  logic                   iFilterFinished;
  logic [WIDTH_BITS-1:0]  iFilterCol;
  logic [HEIGHT_BITS-1:0] iFilterRow;
  logic [WIDTH_BITS-1:0]  oImageCol;
  logic [HEIGHT_BITS-1:0] oImageRow;
  logic [7:0]             iImageData;
  logic [WIDTH_BITS-1:0]  oMeanCol;
  logic [HEIGHT_BITS-1:0] oMeanRow;
  logic [7:0]             iMeanData;
  logic [WIDTH_BITS-1:0]  oOutCol;
  logic [HEIGHT_BITS-1:0] oOutRow;
  logic [7:0]             oOutData;
  logic                   oOutWren;

  modport master (
    input  iStart, iOffset, iFilterFinished, iFilterCol, iFilterRow,
           iImageData, iMeanData,
    output oBusy, oDone, oFilterReset, oImageCol, oImageRow,
           oMeanCol, oMeanRow, oOutCol, oOutRow, oOutData, oOutWren
  );

  modport slave (
    output iStart, iOffset, iFilterFinished, iFilterCol, iFilterRow,
           iImageData, iMeanData,
    input  oBusy, oDone, oFilterReset, oImageCol, oImageRow,
           oMeanCol, oMeanRow, oOutCol, oOutRow, oOutData, oOutWren
  );
endinterface

// File: rtl/threshold_scanner.sv
// Raster scanner for the threshold pass: one pixel per cycle, registered write.
// Define THRESH_INVERT_EN for dark-foreground output polarity.
module threshold_scanner
  import adaptive_threshold_pkg::*;
#(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8,
  parameter int WIDTH       = 2 ** WIDTH_BITS,
  parameter int HEIGHT      = 2 ** HEIGHT_BITS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [7:0]             offset,
  input  logic [7:0]             image_data,
  input  logic [7:0]             mean_data,
  output logic [WIDTH_BITS-1:0]  pix_col,
  output logic [HEIGHT_BITS-1:0] pix_row,
  output logic                   last,
  output logic [WIDTH_BITS-1:0]  out_col,
  output logic [HEIGHT_BITS-1:0] out_row,
  output logic [7:0]             out_data,
  output logic                   out_wren
);

  localparam int POS_W = WIDTH_BITS + HEIGHT_BITS;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(WIDTH * HEIGHT - 1);

  logic [POS_W-1:0]       pos_p0;
  logic [WIDTH_BITS-1:0]  col_p1;
  logic [HEIGHT_BITS-1:0] row_p1;
  logic [7:0]             data_p1;
  logic                   vld_p1;

`ifdef THRESH_INVERT_EN
  function automatic logic [7:0] binarize(input logic fg);
    return fg ? BG_VALUE : FG_VALUE;
  endfunction
`else
  function automatic logic [7:0] binarize(input logic fg);
    return fg ? FG_VALUE : BG_VALUE;
  endfunction
`endif

  assign pix_col = pos_p0[WIDTH_BITS-1:0];
  assign pix_row = pos_p0[POS_W-1:WIDTH_BITS];
  assign last    = (pos_p0 == LAST_POS);

  // p0: address memories from pos; p1: registered write of that pixel.
  // Position is held at 0 whenever disabled, so every run starts at pixel 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pos_p0  <= '0;
      col_p1  <= '0;
      row_p1  <= '0;
      data_p1 <= 8'd0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= enable;
      if (enable) begin
        pos_p0  <= pos_p0 + 1'b1;
        col_p1  <= pix_col;
        row_p1  <= pix_row;
        data_p1 <= binarize(is_foreground(image_data, offset, mean_data));
      end else begin
        pos_p0 <= '0;
      end
    end
  end

  assign out_col  = col_p1;
  assign out_row  = row_p1;
  assign out_data = data_p1;
  assign out_wren = vld_p1;

endmodule

// File: rtl/adaptive_threshold_ctrl.sv
// Adaptive threshold sequencer: box-filter pass, then per-pixel threshold pass.
// Output polarity selectable with THRESH_INVERT_EN (see threshold_scanner).
module adaptive_threshold_ctrl
  import adaptive_threshold_pkg::*;
#(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8,
  parameter int WIDTH       = 2 ** WIDTH_BITS,
  parameter int HEIGHT      = 2 ** HEIGHT_BITS
) (
  input logic                 clock,
  input logic                 reset,
  adaptive_threshold_ctrl_if.master bus
);

  state_t     state, state_next;
  logic [7:0] offset;
  logic       start_accept;
  logic       scan_en;
  logic       scan_last;

  logic [WIDTH_BITS-1:0]  scan_col;
  logic [HEIGHT_BITS-1:0] scan_row;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      offset <= 8'd0;
    end else begin
      state <= state_next;
      if (start_accept) offset <= bus.iOffset;
    end
  end

  always_comb begin
    state_next   = state;
    start_accept = 1'b0;
    scan_en      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.iStart) begin
          start_accept = 1'b1;
          state_next   = BLUR;
        end
      end
      BLUR:   if (bus.iFilterFinished) state_next = THRESH;
      THRESH: begin
        scan_en = 1'b1;
        if (scan_last) state_next = FLUSH;
      end
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Filter is held in reset whenever no blur/threshold work is pending,
  // which also guarantees iFilterFinished reads 0 on BLUR entry.
  assign bus.oFilterReset = (state == IDLE) || (state == DONE);
  assign bus.oBusy        = (state == BLUR) || (state == THRESH) || (state == FLUSH);
  assign bus.oDone        = (state == DONE);

  // Single source-image port: filter owns it during BLUR, scanner otherwise.
  assign bus.oImageCol = (state == BLUR) ? bus.iFilterCol : scan_col;
  assign bus.oImageRow = (state == BLUR) ? bus.iFilterRow : scan_row;
  assign bus.oMeanCol  = scan_col;
  assign bus.oMeanRow  = scan_row;

  threshold_scanner #(
    .WIDTH_BITS  (WIDTH_BITS),
    .HEIGHT_BITS (HEIGHT_BITS),
    .WIDTH       (WIDTH),
    .HEIGHT      (HEIGHT)
  ) u_scanner (
    .clock      (clock),
    .reset      (reset),
    .enable     (scan_en),
    .offset     (offset),
    .image_data (bus.iImageData),
    .mean_data  (bus.iMeanData),
    .pix_col    (scan_col),
    .pix_row    (scan_row),
    .last       (scan_last),
    .out_col    (bus.oOutCol),
    .out_row    (bus.oOutRow),
    .out_data   (bus.oOutData),
    .out_wren   (bus.oOutWren)
  );

endmodule
